// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the sequential restoring divider.
//   M_DIV / D_DIV : dividend/quotient and divisor/remainder widths. M_DIV is
//                   also the unsigned operand width of the downstream
//                   multiplier that scales the quotient by the sine sample.
//   div_state_e   : divider FSM state encoding.
//   DBZ_QUOT      : quotient reported when the divisor is zero (all ones).
// ----------------------------------------------------------------------------
package div_pkg;

  localparam int M_DIV = 26;
  localparam int D_DIV = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  localparam logic [M_DIV-1:0] DBZ_QUOT = {M_DIV{1'b1}};

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   p_in    : current partial remainder (D bits)
//   q_msb   : dividend/quotient shift register MSB shifted into the remainder
//   divisor : latched divisor
//   p_out   : next partial remainder
//   q_bit   : quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int D = D_DIV
) (
  input  logic [D-1:0] p_in,
  input  logic         q_msb,
  input  logic [D-1:0] divisor,
  output logic [D-1:0] p_out,
  output logic         q_bit
);

  logic [D:0] trial;

  // D+1-bit subtract so the MSB is the borrow. If the shifted-in value has
  // its top bit set it exceeds any divisor, so the subtract always succeeds
  // there; the restored value therefore always fits back into D bits.
  always_comb begin
    trial = {p_in, q_msb} - {1'b0, divisor};
    q_bit = ~trial[D];
    p_out = q_bit ? trial[D-1:0] : {p_in[D-2:0], q_msb};
  end

endmodule

// File: rtl/div_restoring_seq.sv
// ----------------------------------------------------------------------------
// div_restoring_seq
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, accepted only while idle
//   dividend     : M-bit numerator, captured on accept
//   divisor      : D-bit denominator, captured on accept
//   ready        : high while idle
//   done         : one-cycle pulse when a new result is presented
//   quotient     : M-bit result, held until the next result
//   remainder    : D-bit remainder, held the same way
//   div_by_zero  : set with a result produced from a zero divisor
// ----------------------------------------------------------------------------
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int M = M_DIV,
  parameter int D = D_DIV
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(M);

  div_state_e state_q, state_d;
  logic [D-1:0]     p_q, p_d;
  logic [M-1:0]     q_sh_q, q_sh_d;
  logic [D-1:0]     div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     quot_q, quot_d;
  logic [D-1:0]     rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [D-1:0] step_p;
  logic         step_qbit;

  div_step #(.D(D)) u_step (
    .p_in    (p_q),
    .q_msb   (q_sh_q[M-1]),
    .divisor (div_q),
    .p_out   (step_p),
    .q_bit   (step_qbit)
  );

  // The result registers are loaded on the same edge that enters FIN, so the
  // last iteration's step outputs feed them directly.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_sh_d  = q_sh_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_d  = divisor;
          q_sh_d = dividend;
          p_d    = '0;
          if (divisor == '0) begin
            // Remainder reports the dividend truncated to D bits (D <= M).
            state_d = ST_FIN;
            cnt_d   = '0;
            quot_d  = M'(DBZ_QUOT);
            rem_d   = dividend[D-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(M - 1);
          end
        end
      end
      ST_CALC: begin
        p_d    = step_p;
        q_sh_d = {q_sh_q[M-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = ST_FIN;
          quot_d  = {q_sh_q[M-2:0], step_qbit};
          rem_d   = step_p;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      q_sh_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_sh_q  <= q_sh_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// ----------------------------------------------------------------------------
// tb_div_restoring_seq
// Directed and randomised checks of the sequential restoring divider.
// ----------------------------------------------------------------------------
module tb_div_restoring_seq;

  localparam int M = 26;
  localparam int D = 26;
  localparam logic [M-1:0] ALL1 = 26'h3FFFFFF;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [M-1:0] dividend;
  logic [D-1:0] divisor;
  logic         ready;
  logic         done;
  logic [M-1:0] quotient;
  logic [D-1:0] remainder;
  logic         div_by_zero;

  int vec_cnt;
  int err_cnt;

  logic [M-1:0] prev_q;
  logic [D-1:0] prev_r;
  logic         prev_z;

  div_restoring_seq #(.M(M), .D(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a division just after a rising edge and waits for done.
  // cycles = edges from the driving edge to done (-1 on timeout).
  task automatic run_div(input logic [M-1:0] a, input logic [D-1:0] b,
                         output int cycles, output bit ready_seen);
    cycles     = -1;
    ready_seen = 1'b0;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        cycles = n;
        break;
      end
      if (ready) ready_seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    vec_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vec_cnt++; if (quotient !== '0) begin err_cnt++; $display("[TB] FAIL reset_quot: got %0d want 0", quotient); end
    vec_cnt++; if (remainder !== '0) begin err_cnt++; $display("[TB] FAIL reset_rem: got %0d want 0", remainder); end
    vec_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_dbz: got %b want 0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_normal;
    int cyc; bit rs;
    run_div(26'd1000, 26'd7, cyc, rs);
    vec_cnt++; if (cyc !== 27) begin err_cnt++; $display("[TB] FAIL normal_latency: got %0d want 27", cyc); end
    vec_cnt++; if (rs !== 1'b0) begin err_cnt++; $display("[TB] FAIL normal_ready_busy: got %b want 0", rs); end
    vec_cnt++; if (ready !== 1'b0) begin err_cnt++; $display("[TB] FAIL normal_ready_fin: got %b want 0", ready); end
    vec_cnt++; if (quotient !== 26'd142) begin err_cnt++; $display("[TB] FAIL normal_quot: got %0d want 142", quotient); end
    vec_cnt++; if (remainder !== 26'd6) begin err_cnt++; $display("[TB] FAIL normal_rem: got %0d want 6", remainder); end
    vec_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("[TB] FAIL normal_dbz: got %b want 0", div_by_zero); end
    @(posedge clk); #1;
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("[TB] FAIL normal_done_pulse: got %b want 0", done); end
    vec_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("[TB] FAIL normal_ready_idle: got %b want 1", ready); end
    vec_cnt++; if (quotient !== 26'd142) begin err_cnt++; $display("[TB] FAIL normal_hold: got %0d want 142", quotient); end
  endtask

  task automatic test_back_to_back;
    int first_done, second_done;
    first_done = -1; second_done = -1;
    @(posedge clk); #1;
    dividend = ALL1; divisor = 26'd1; start = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk); #1;
      if (done && first_done < 0) begin
        first_done = n;
        vec_cnt++; if (quotient !== ALL1) begin err_cnt++; $display("[TB] FAIL b2b_max_quot: got %h want %h", quotient, ALL1); end
        vec_cnt++; if (remainder !== '0) begin err_cnt++; $display("[TB] FAIL b2b_max_rem: got %0d want 0", remainder); end
        dividend = 26'd5; divisor = 26'd9;
      end else if (done) begin
        second_done = n;
        start = 1'b0;
        vec_cnt++; if (quotient !== '0) begin err_cnt++; $display("[TB] FAIL b2b_small_quot: got %0d want 0", quotient); end
        vec_cnt++; if (remainder !== 26'd5) begin err_cnt++; $display("[TB] FAIL b2b_small_rem: got %0d want 5", remainder); end
        break;
      end
    end
    start = 1'b0;
    vec_cnt++; if (first_done !== 27) begin err_cnt++; $display("[TB] FAIL b2b_first_latency: got %0d want 27", first_done); end
    vec_cnt++; if (second_done - first_done !== 28) begin err_cnt++; $display("[TB] FAIL b2b_spacing: got %0d want 28", second_done - first_done); end
  endtask

  task automatic test_div_zero;
    int cyc; bit rs;
    run_div(26'd1234, 26'd0, cyc, rs);
    vec_cnt++; if (cyc !== 1) begin err_cnt++; $display("[TB] FAIL dbz_latency: got %0d want 1", cyc); end
    vec_cnt++; if (quotient !== ALL1) begin err_cnt++; $display("[TB] FAIL dbz_quot: got %h want %h", quotient, ALL1); end
    vec_cnt++; if (remainder !== 26'd1234) begin err_cnt++; $display("[TB] FAIL dbz_rem: got %0d want 1234", remainder); end
    vec_cnt++; if (div_by_zero !== 1'b1) begin err_cnt++; $display("[TB] FAIL dbz_flag: got %b want 1", div_by_zero); end
    run_div(26'd10, 26'd3, cyc, rs);
    vec_cnt++; if (cyc !== 27) begin err_cnt++; $display("[TB] FAIL dbz_after_latency: got %0d want 27", cyc); end
    vec_cnt++; if (quotient !== 26'd3) begin err_cnt++; $display("[TB] FAIL dbz_after_quot: got %0d want 3", quotient); end
    vec_cnt++; if (remainder !== 26'd1) begin err_cnt++; $display("[TB] FAIL dbz_after_rem: got %0d want 1", remainder); end
    vec_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("[TB] FAIL dbz_after_flag: got %b want 0", div_by_zero); end
  endtask

  task automatic test_boundaries;
    logic [M-1:0] ta [5] = '{ALL1, 26'd12, 26'd0, ALL1, 26'd1};
    logic [D-1:0] tb [5] = '{ALL1, 26'd12, 26'd5, 26'd2, ALL1};
    logic [M-1:0] tq [5] = '{26'd1, 26'd1, 26'd0, 26'h1FFFFFF, 26'd0};
    logic [D-1:0] tr [5] = '{26'd0, 26'd0, 26'd0, 26'd1, 26'd1};
    int cyc; bit rs;
    for (int i = 0; i < 5; i++) begin
      run_div(ta[i], tb[i], cyc, rs);
      vec_cnt++; if (quotient !== tq[i]) begin err_cnt++; $display("[TB] FAIL bound%0d_quot: got %h want %h", i, quotient, tq[i]); end
      vec_cnt++; if (remainder !== tr[i]) begin err_cnt++; $display("[TB] FAIL bound%0d_rem: got %h want %h", i, remainder, tr[i]); end
    end
  endtask

  task automatic test_busy_ignored;
    int dones;
    logic [M-1:0] got_q;
    logic [D-1:0] got_r;
    dones = 0; got_q = '1; got_r = '1;
    @(posedge clk); #1;
    dividend = 26'd100; divisor = 26'd10; start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (n == 5) begin dividend = 26'd50; divisor = 26'd5; start = 1'b1; end
      if (n == 15) start = 1'b0;
      if (done) begin
        dones++;
        got_q = quotient;
        got_r = remainder;
      end
    end
    vec_cnt++; if (dones !== 1) begin err_cnt++; $display("[TB] FAIL busy_done_count: got %0d want 1", dones); end
    vec_cnt++; if (got_q !== 26'd10) begin err_cnt++; $display("[TB] FAIL busy_quot: got %0d want 10", got_q); end
    vec_cnt++; if (got_r !== 26'd0) begin err_cnt++; $display("[TB] FAIL busy_rem: got %0d want 0", got_r); end
  endtask

  task automatic test_reset_mid;
    int cyc; bit rs;
    @(posedge clk); #1;
    dividend = 26'd999; divisor = 26'd4; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("[TB] FAIL midrst_ready: got %b want 1", ready); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
    vec_cnt++; if (quotient !== '0) begin err_cnt++; $display("[TB] FAIL midrst_quot: got %0d want 0", quotient); end
    vec_cnt++; if (remainder !== '0) begin err_cnt++; $display("[TB] FAIL midrst_rem: got %0d want 0", remainder); end
    @(negedge clk); rst_n = 1'b1;
    run_div(26'd999, 26'd4, cyc, rs);
    vec_cnt++; if (cyc !== 27) begin err_cnt++; $display("[TB] FAIL midrst_after_latency: got %0d want 27", cyc); end
    vec_cnt++; if (quotient !== 26'd249) begin err_cnt++; $display("[TB] FAIL midrst_after_quot: got %0d want 249", quotient); end
    vec_cnt++; if (remainder !== 26'd3) begin err_cnt++; $display("[TB] FAIL midrst_after_rem: got %0d want 3", remainder); end
    prev_q = 26'd249; prev_r = 26'd3; prev_z = 1'b0;
  endtask

  task automatic test_random;
    logic [M-1:0] a, eq;
    logic [D-1:0] b, er;
    logic         ez;
    int  cyc;
    bit  moved;
    for (int v = 0; v < 300; v++) begin
      a = M'($urandom);
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = D'($urandom_range(1, 15));
        2: b = a;
        3: b = D'($urandom);
        default: b = D'($urandom) >> $urandom_range(0, 25);
      endcase
      if (b == '0) begin eq = ALL1; er = a; ez = 1'b1; end
      else begin eq = a / b; er = a % b; ez = 1'b0; end
      cyc = -1; moved = 1'b0;
      @(posedge clk); #1;
      dividend = a; divisor = b; start = 1'b1;
      for (int n = 1; n <= 100; n++) begin
        @(posedge clk); #1;
        start = 1'b0;
        dividend = M'($urandom);
        divisor  = D'($urandom);
        if (done) begin cyc = n; break; end
        if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_z) moved = 1'b1;
      end
      vec_cnt++; if (moved !== 1'b0) begin err_cnt++; $display("[TB] FAIL rand%0d_stable: outputs changed before done, want held %h/%h", v, prev_q, prev_r); end
      vec_cnt++; if (cyc !== (ez ? 1 : 27)) begin err_cnt++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", v, cyc, ez ? 1 : 27); end
      vec_cnt++; if (quotient !== eq) begin err_cnt++; $display("[TB] FAIL rand%0d_quot: %h/%h got %h want %h", v, a, b, quotient, eq); end
      vec_cnt++; if (remainder !== er) begin err_cnt++; $display("[TB] FAIL rand%0d_rem: %h/%h got %h want %h", v, a, b, remainder, er); end
      vec_cnt++; if (div_by_zero !== ez) begin err_cnt++; $display("[TB] FAIL rand%0d_dbz: got %b want %b", v, div_by_zero, ez); end
      prev_q = eq; prev_r = er; prev_z = ez;
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    $display("[TB] starting div_restoring_seq bench");
    test_reset();
    test_normal();
    test_back_to_back();
    test_div_zero();
    test_boundaries();
    test_busy_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
